// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, frame width and a constant clog2.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Fractional-accumulator tick generator running at BAUD*OVERSAMPLING.
// The tick is the registered carry out of a phase accumulator.
module uart_os_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = clog2(CLK_FREQ / BAUD) + 8;
    // Rounded 2^W * tick_rate / CLK_FREQ, evaluated in 64 bits
    localparam longint unsigned INC64 =
        (((64'(BAUD) * 64'(OVERSAMPLING)) << W) + 64'(CLK_FREQ / 2))
        / 64'(CLK_FREQ);
    localparam logic [W-1:0] INC = W'(INC64);

    logic [W-1:0] acc_q, acc_d;
    logic         tick_q, tick_d;
    logic [W:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, INC};
        acc_d  = sum[W-1:0];
        tick_d = sum[W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_async_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1.
// Oversampled mid-bit sampling of a 2-FF synchronised rxd.
module uart_async_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int CW = clog2(OVERSAMPLING);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLING - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic tick;

    uart_os_tick_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .OVERSAMPLING(OVERSAMPLING)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    rx_state_e   state_q, state_d;
    logic [1:0]  sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bitidx_q, bitidx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        ferr_q, ferr_d;
    logic        perr_q, perr_d;
    logic        pbad_q, pbad_d;
    logic        rxd_s;

    assign sync_d = {sync_q[0], rxd};
    assign rxd_s  = sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        pbad_d   = pbad_q;
        ready_d  = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d    = '0;
                        bitidx_d = '0;
                        pbad_d   = 1'b0;
                        state_d  = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d   = '0;
                        shreg_d = {rxd_s, shreg_q[7:1]};
                        if (bitidx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bitidx_d = bitidx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt_q == CNT_END) begin
                        cnt_d   = '0;
                        pbad_d  = rxd_s ^ (^shreg_q);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
                STOP: begin
                    if (cnt_q == CNT_END) begin
                        // Leave at mid-stop so a back-to-back start is caught
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (!rxd_s) begin
                            ferr_d = 1'b1;
                        end else if (pbad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            ready_d = 1'b1;
                            data_d  = shreg_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            pbad_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            pbad_q   <= pbad_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_ready = ready_q;
    assign frame_err     = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err    = perr_q;
`else
    assign parity_err    = 1'b0;
`endif
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_async_rx.sv
// Scoreboard bench for uart_async_rx with a frame-level reference model.
// Honours UART_RX_PARITY_EN to send and expect 8E1 frames.
module tb_uart_async_rx;

    localparam int BIT_CLK = 434;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    uart_async_rx #(
        .CLK_FREQ    (50000000),
        .BAUD        (115200),
        .OVERSAMPLING(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_data_ready(rx_data_ready),
        .frame_err    (frame_err),
        .parity_err   (parity_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         checks;
    int         errors;
    logic [7:0] last_good;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame-level model: stop error beats parity error beats good data
    function automatic ev_t model(input logic [7:0] d, input logic stop_b,
                                  input logic par_bit);
        ev_t e;
        e.data = d;
        if (!stop_b)
            e.kind = 1;
        else if (par_bit != ^d)
            e.kind = 2;
        else
            e.kind = 0;
        return e;
    endfunction

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic par_flip, input int gap);
        logic par_bit;
`ifdef UART_RX_PARITY_EN
        par_bit = (^d) ^ par_flip;
`else
        par_bit = ^d;
`endif
        exp_q.push_back(model(d, stop_b, par_bit));
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_b);
        rxd = 1'b1;
        for (int i = 0; i < gap; i++) drive_bit(1'b1);
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (rst_n && (rx_data_ready || frame_err || parity_err)) begin
            k = rx_data_ready ? 0 : (frame_err ? 1 : 2);
            checks++;
            if (32'(rx_data_ready) + 32'(frame_err) + 32'(parity_err) > 1) begin
                errors++;
                $display("FAIL pulse_overlap: rdy=%0b ferr=%0b perr=%0b",
                         rx_data_ready, frame_err, parity_err);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: kind %0d, data %0h", k, rx_data);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k) begin
                    errors++;
                    $display("FAIL event_kind: got %0d, expected %0d (byte %0h)",
                             k, e.kind, e.data);
                end else if (k == 0 && rx_data !== e.data) begin
                    errors++;
                    $display("FAIL rx_data: got %0h, expected %0h", rx_data, e.data);
                end else if (k != 0 && rx_data !== last_good) begin
                    errors++;
                    $display("FAIL rx_data_held: got %0h, expected %0h",
                             rx_data, last_good);
                end
                if (k == 0) last_good = e.data;
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pf;
        int         gap;
        checks    = 0;
        errors    = 0;
        last_good = 8'h00;
        rxd       = 1'b1;
        rst_n     = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_ready", 32'(rx_data_ready), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_parity_err", 32'(parity_err), 32'h0);
        chk("reset_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(posedge clk);

        send_frame(8'h55, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("busy_after_55", 32'(rx_busy), 32'h0);
        drive_bit(1'b1);

        send_frame(8'hA3, 1'b1, 1'b0, 0);
        send_frame(8'h0F, 1'b1, 1'b0, 1);

        rxd = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_high", 32'(rx_busy), 32'h1);
        repeat (19) @(posedge clk);
        rxd = 1'b1;
        repeat (400) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_low", 32'(rx_busy), 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0, 2);

        d = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rxd = d[4];
        repeat (200) @(posedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("midreset_rx_data", 32'(rx_data), 32'h0);
        chk("midreset_ready", 32'(rx_data_ready), 32'h0);
        chk("midreset_ferr", 32'(frame_err), 32'h0);
        chk("midreset_perr", 32'(parity_err), 32'h0);
        chk("midreset_busy", 32'(rx_busy), 32'h0);
        last_good = 8'h00;
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(posedge clk);
        send_frame(8'hC4, 1'b1, 1'b0, 1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b0, 1);
        send_frame(8'h81, 1'b1, 1'b1, 1);
`endif

        for (int n = 0; n < 4; n++) begin
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 5) != 0);
            pf  = ($urandom_range(0, 4) == 0);
            gap = sb ? $urandom_range(0, 1) : 1;
            send_frame(d, sb, pf, gap);
        end

        repeat (1000) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
